// File: rtl/readout_stream_scheduler_if.sv
// Source-FIFO / output-stream bundle between the readout stream scheduler and its
// surroundings. The scheduler side is master; the FIFO/sink side is slave.
`timescale 1ns/1ps
interface readout_stream_scheduler_if #(
   parameter int N    = 7,
   parameter int DW   = 32,
   parameter int IDXW = 3
);
   logic [N-1:0]    SRC_EMPTY;
   logic [N*DW-1:0] SRC_DATA;
   logic [N-1:0]    SRC_READ;
   logic [N-1:0]    SRC_EN;
   logic [7:0]      BURST_LEN;
   logic            READY_OUT;
   logic            WRITE_OUT;
   logic [DW-1:0]   DATA_OUT;
   logic [IDXW-1:0] GRANT_IDX;
   logic            BUSY;
   logic [31:0]     WORD_CNT;

   modport master (
      input  SRC_EMPTY, SRC_DATA, SRC_EN, BURST_LEN, READY_OUT,
      output SRC_READ, WRITE_OUT, DATA_OUT, GRANT_IDX, BUSY, WORD_CNT
   );

   modport slave (
      output SRC_EMPTY, SRC_DATA, SRC_EN, BURST_LEN, READY_OUT,
      input  SRC_READ, WRITE_OUT, DATA_OUT, GRANT_IDX, BUSY, WORD_CNT
   );
endinterface

// File: rtl/readout_stream_scheduler.sv
// Round-robin merge of N FWFT source FIFOs into one word stream, holding each
// grant for up to BURST_LEN words so multi-word records stay contiguous.
`timescale 1ns/1ps
module readout_stream_scheduler #(
   parameter int N    = 7,
   parameter int DW   = 32,
   parameter int IDXW = 3
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   readout_stream_scheduler_if.master bus
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t          state_q, state_d;
   logic [IDXW-1:0] ptr_q;
   logic [IDXW-1:0] grant_q;
   logic [7:0]      cnt_q;
   logic [7:0]      blen_q;

   logic            vld_p1;
   logic [DW-1:0]   data_p1;
   logic [31:0]     word_cnt_q;

   logic [N-1:0]    req;
   logic            req_g;
   logic [DW-1:0]   word_g;
   logic            hit;
   logic [IDXW-1:0] pick;
   logic            pop;
   logic            load;
   logic            leave;
   logic [N-1:0]    src_read;

   // First requester after p, walking upward and wrapping; result is {hit, index}.
   function automatic logic [IDXW:0] rr_pick(input logic [N-1:0] r, input logic [IDXW-1:0] p);
      logic [IDXW:0] res;
      int            best_d;
      int            d;
      res    = '0;
      best_d = N;
      for (int i = 0; i < N; i++) begin
         d = (i + N - int'(p) - 1) % N;
         if (r[i] && (d < best_d)) begin
            best_d = d;
            res    = {1'b1, IDXW'(i)};
         end
      end
      return res;
   endfunction

   assign req = bus.SRC_EN & ~bus.SRC_EMPTY;

   always_comb begin
      req_g  = 1'b0;
      word_g = '0;
      for (int i = 0; i < N; i++) begin
         if (grant_q == IDXW'(i)) begin
            req_g  = req[i];
            word_g = bus.SRC_DATA[i*DW +: DW];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      pop         = 1'b0;
      load        = 1'b0;
      leave       = 1'b0;
      {hit, pick} = rr_pick(req, ptr_q);
      case (state_q)
         IDLE: begin
            if (hit && bus.READY_OUT) begin
               load    = 1'b1;
               state_d = GRANT;
            end
         end
         GRANT: begin
            pop = bus.READY_OUT & req_g;
            // A drained source is seen as req_g==0 one cycle after its last pop.
            if (!req_g || (pop && (blen_q != 8'd0) && (cnt_q == blen_q - 8'd1))) begin
               leave   = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ptr_q   <= IDXW'(N-1);
         grant_q <= '0;
         cnt_q   <= '0;
         blen_q  <= '0;
      end else if (load) begin
         grant_q <= pick;
         cnt_q   <= '0;
         blen_q  <= bus.BURST_LEN;
      end else begin
         if (pop) begin
            cnt_q <= cnt_q + 8'd1;
         end
         if (leave) begin
            ptr_q <= grant_q;
         end
      end
   end

   // Stage p1: popped word registered toward the output FIFO.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         vld_p1     <= 1'b0;
         data_p1    <= '0;
         word_cnt_q <= '0;
      end else begin
         vld_p1 <= pop;
         if (pop) begin
            data_p1 <= word_g;
         end
         if (vld_p1) begin
            word_cnt_q <= word_cnt_q + 32'd1;
         end
      end
   end

   always_comb begin
      src_read = '0;
      for (int i = 0; i < N; i++) begin
         src_read[i] = pop && (grant_q == IDXW'(i));
      end
   end

   assign bus.SRC_READ  = src_read;
   assign bus.WRITE_OUT = vld_p1;
   assign bus.DATA_OUT  = data_p1;
   assign bus.GRANT_IDX = grant_q;
   assign bus.BUSY      = (state_q == GRANT);
   assign bus.WORD_CNT  = word_cnt_q;

endmodule

// File: tb/tb_readout_stream_scheduler.sv
// Bench for readout_stream_scheduler: behavioural FIFO sources, a transaction-level
// reference model checked every cycle, a directed table and corner-case sequences.
`timescale 1ns/1ps
module tb_readout_stream_scheduler;
   localparam int N    = 7;
   localparam int DW   = 32;
   localparam int IDXW = 3;

   typedef struct {
      logic [N-1:0] mask;
      int           words;
      logic [7:0]   blen;
      int           exp_writes;
      int           exp_grant;
   } rec_t;

   logic CLK = 1'b0;
   logic RST_N;
   always #5 CLK = ~CLK;

   readout_stream_scheduler_if #(.N(N), .DW(DW), .IDXW(IDXW)) bus ();
   readout_stream_scheduler #(.N(N), .DW(DW), .IDXW(IDXW)) dut (
      .CLK  (CLK),
      .RST_N(RST_N),
      .bus  (bus)
   );

   logic [DW-1:0] mem [N][1024];
   logic [9:0]    rd [N];
   logic [9:0]    wr [N];
   int            occ [N];
   int            seq [N];
   int            pops [N];
   logic [N-1:0]  drv_en;
   logic          drv_ready;
   logic [7:0]    drv_blen;

   // Reference model: owner<0 means no grant; used/limit count words in this grant.
   int            m_owner, m_ptr, m_used, m_limit, m_gidx;
   logic          m_wr;
   logic [DW-1:0] m_data;
   logic [31:0]   m_cnt;

   int            n_vec = 0;
   int            n_miss = 0;
   int            n_writes = 0;
   logic [DW-1:0] out_log [$];
   rec_t          tbl [5];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      n_vec++;
      n_miss++;
      $display("FAIL %s: wait bound expired, got no event, expected one (t=%0t)", name, $time);
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         bus.SRC_EMPTY[i]          = (occ[i] == 0);
         bus.SRC_DATA[i*DW +: DW]  = mem[i][rd[i]];
      end
      bus.SRC_EN    = drv_en;
      bus.READY_OUT = drv_ready;
      bus.BURST_LEN = drv_blen;
   endtask

   task automatic push(input int s, input int n);
      for (int k = 0; k < n; k++) begin
         mem[s][wr[s]] = {4'(s), 28'(seq[s])};
         wr[s] = wr[s] + 10'd1;
         occ[s]++;
         seq[s]++;
      end
      drive();
   endtask

   task automatic clear_fifos();
      for (int i = 0; i < N; i++) begin
         rd[i] = '0; wr[i] = '0; occ[i] = 0; seq[i] = 0; pops[i] = 0;
      end
      n_writes = 0;
      out_log.delete();
      drive();
   endtask

   task automatic model_reset();
      m_owner = -1; m_ptr = N - 1; m_used = 0; m_limit = 0; m_gidx = 0;
      m_wr = 1'b0; m_data = '0; m_cnt = '0;
   endtask

   function automatic bit mreq(input int i);
      return drv_en[i] && (occ[i] != 0);
   endfunction

   function automatic bit idle_now();
      bit any;
      any = 1'b0;
      for (int i = 0; i < N; i++) if (mreq(i)) any = 1'b1;
      return !bus.BUSY && !bus.WRITE_OUT && !any;
   endfunction

   // 3 ns asynchronous reset pulse placed between clock edges.
   task automatic reset_pulse();
      RST_N = 1'b0;
      #1;
      chk("rst_src_read", bus.SRC_READ, 0);
      chk("rst_write_out", bus.WRITE_OUT, 0);
      chk("rst_data_out", bus.DATA_OUT, 0);
      chk("rst_word_cnt", bus.WORD_CNT, 0);
      chk("rst_busy", bus.BUSY, 0);
      chk("rst_grant_idx", bus.GRANT_IDX, 0);
      model_reset();
      #2;
      RST_N = 1'b1;
   endtask

   // Called at a falling edge with inputs settled; returns at the next falling edge.
   task automatic step();
      int           ps;
      int           g;
      int           j;
      logic [N-1:0] exp_rd;
      logic [N-1:0] act_rd;
      #1;
      ps = (m_owner >= 0 && drv_ready && mreq(m_owner)) ? m_owner : -1;
      exp_rd = '0;
      if (ps >= 0) exp_rd[ps] = 1'b1;
      chk("src_read", bus.SRC_READ, exp_rd);
      chk("write_out", bus.WRITE_OUT, m_wr);
      chk("data_out", bus.DATA_OUT, m_data);
      chk("word_cnt", bus.WORD_CNT, m_cnt);
      chk("busy", bus.BUSY, m_owner >= 0);
      chk("grant_idx", bus.GRANT_IDX, m_gidx);
      if (bus.WRITE_OUT) begin
         n_writes++;
         out_log.push_back(bus.DATA_OUT);
      end
      act_rd = bus.SRC_READ;

      m_cnt = m_cnt + 32'(m_wr);
      m_wr  = (ps >= 0);
      if (ps >= 0) m_data = mem[ps][rd[ps]];
      if (m_owner < 0) begin
         g = -1;
         for (int k = 1; k <= N; k++) begin
            j = (m_ptr + k) % N;
            if (g < 0 && mreq(j)) g = j;
         end
         if (g >= 0 && drv_ready) begin
            m_owner = g; m_gidx = g; m_used = 0; m_limit = int'(drv_blen);
         end
      end else begin
         if (ps >= 0) m_used++;
         if (!mreq(m_owner) || (ps >= 0 && m_limit != 0 && m_used == m_limit)) begin
            m_ptr = m_owner;
            m_owner = -1;
         end
      end

      @(posedge CLK);
      @(negedge CLK);
      for (int i = 0; i < N; i++) begin
         if (act_rd[i] && occ[i] > 0) begin
            rd[i] = rd[i] + 10'd1;
            occ[i]--;
            pops[i]++;
         end
      end
      drive();
   endtask

   task automatic run_idle(input int budget, input string name);
      int b;
      b = 0;
      while (!idle_now() && b < budget) begin
         step();
         b++;
      end
      if (!idle_now()) timeout(name);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] w;
      int            w0;
      int            b;
      int            left2;
      int            idx;

      tbl[0] = '{7'h7F, 4,   8'd2, 28,  6};
      tbl[1] = '{7'h08, 300, 8'd0, 300, 3};
      tbl[2] = '{7'h05, 3,   8'd1, 6,   2};
      tbl[3] = '{7'h41, 5,   8'd3, 10,  6};
      tbl[4] = '{7'h30, 2,   8'd0, 4,   5};

      drv_en = '1; drv_ready = 1'b1; drv_blen = 8'd0;
      for (int i = 0; i < N; i++) for (int k = 0; k < 1024; k++) mem[i][k] = '0;
      RST_N = 1'b0;
      clear_fifos();
      model_reset();
      repeat (3) @(negedge CLK);
      reset_pulse();

      // Directed table: sources loaded equally, READY_OUT held high.
      for (int r = 0; r < 5; r++) begin
         clear_fifos();
         drv_en = '1; drv_ready = 1'b1; drv_blen = tbl[r].blen;
         drive();
         reset_pulse();
         for (int i = 0; i < N; i++) if (tbl[r].mask[i]) push(i, tbl[r].words);
         run_idle(2000, "table_drain");
         chk("table_writes", n_writes, tbl[r].exp_writes);
         chk("table_word_cnt", bus.WORD_CNT, tbl[r].exp_writes);
         chk("table_last_grant", bus.GRANT_IDX, tbl[r].exp_grant);
         if (r == 0) begin
            for (int k = 0; k < 28; k++) begin
               w = (k < out_log.size()) ? out_log[k] : '1;
               chk("rr_order_src", w[31:28], (k / 2) % 7);
            end
         end
      end

      // READY_OUT dropped after the fifth pop of source 1.
      clear_fifos();
      drv_en = '1; drv_ready = 1'b1; drv_blen = 8'd0;
      reset_pulse();
      push(1, 12);
      b = 0;
      while (pops[1] < 5 && b < 100) begin step(); b++; end
      if (pops[1] < 5) timeout("ready_wait_pop5");
      drv_ready = 1'b0;
      drive();
      w0 = n_writes;
      repeat (6) step();
      chk("ready_low_extra_writes_le1", (n_writes - w0) <= 1, 1);
      chk("ready_low_no_pop", pops[1], 5);
      chk("ready_low_busy", bus.BUSY, 1);
      chk("ready_low_grant", bus.GRANT_IDX, 1);
      drv_ready = 1'b1;
      drive();
      run_idle(200, "ready_drain");
      chk("ready_total_writes", n_writes, 12);
      for (int k = 0; k < 12; k++) begin
         w = (k < out_log.size()) ? out_log[k] : '1;
         chk("ready_scoreboard", w, {4'd1, 28'(k)});
      end

      // SRC_EN[2] cleared while source 2 holds the grant.
      clear_fifos();
      drv_en = '1; drv_blen = 8'd0;
      reset_pulse();
      push(2, 8);
      push(4, 4);
      b = 0;
      while (pops[2] < 2 && b < 100) begin step(); b++; end
      if (pops[2] < 2) timeout("en_wait_pop2");
      drv_en[2] = 1'b0;
      drive();
      #1;
      chk("en_drop_read2_same_cycle", bus.SRC_READ[2], 0);
      left2 = occ[2];
      b = 0;
      while (!(bus.BUSY && bus.GRANT_IDX == 3'd4) && b < 50) begin step(); b++; end
      if (!(bus.BUSY && bus.GRANT_IDX == 3'd4)) timeout("en_wait_grant4");
      chk("en_next_grant", bus.GRANT_IDX, 4);
      run_idle(200, "en_drain");
      chk("en_src2_untouched", occ[2], left2);
      chk("en_src2_pops", pops[2], 2);
      chk("en_src4_drained", occ[4], 0);
      drv_en = '1;
      drive();
      run_idle(200, "en_restore_drain");

      // Async reset mid-burst of source 6 after a grant to 3 moved the pointer.
      clear_fifos();
      reset_pulse();
      push(3, 2);
      run_idle(100, "rst_prep_drain");
      push(6, 20);
      b = 0;
      while (pops[6] < 3 && b < 100) begin step(); b++; end
      if (pops[6] < 3) timeout("rst_wait_pop3");
      push(1, 4);
      push(4, 4);
      chk("rst_mid_busy_before", bus.BUSY, 1);
      reset_pulse();
      b = 0;
      while (!bus.BUSY && b < 20) begin step(); b++; end
      if (!bus.BUSY) timeout("rst_wait_regrant");
      chk("rst_first_grant_lowest", bus.GRANT_IDX, 1);
      run_idle(300, "rst_drain");

      // WORD_CNT wrap from a preloaded value.
      force dut.word_cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.word_cnt_q;
      m_cnt = 32'hFFFF_FFFE;
      chk("wrap_preload", bus.WORD_CNT, 32'hFFFF_FFFE);
      push(0, 3);
      run_idle(100, "wrap_drain");
      chk("wrap_word_cnt", bus.WORD_CNT, 32'h0000_0001);

      // Randomized traffic against the reference model.
      clear_fifos();
      drv_en = '1; drv_ready = 1'b1; drv_blen = 8'd2;
      reset_pulse();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int i = 0; i < N; i++) begin
            if (occ[i] < 900 && $urandom_range(0, 99) < 4) push(i, $urandom_range(1, 3));
         end
         drv_ready = ($urandom_range(0, 99) < 80);
         if ($urandom_range(0, 99) < 3) begin
            idx = $urandom_range(0, N - 1);
            drv_en[idx] = ~drv_en[idx];
         end
         if ($urandom_range(0, 199) == 0) drv_en = '1;
         if ($urandom_range(0, 99) < 2) begin
            case ($urandom_range(0, 5))
               0: drv_blen = 8'd0;
               1: drv_blen = 8'd1;
               2: drv_blen = 8'd2;
               3: drv_blen = 8'd3;
               4: drv_blen = 8'd4;
               default: drv_blen = 8'd7;
            endcase
         end
         drive();
         if (cyc % 700 == 350) reset_pulse();
         step();
      end
      drv_en = '1;
      drv_ready = 1'b1;
      drive();
      run_idle(20000, "random_final_drain");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
